// File: rtl/sha256_stream_core.sv
// Handshaked SHA-256/SHA-224 compression engine: one pre-padded 512-bit chunk per
// transaction, ROUNDS_PER_CYCLE rounds per clock, multi-block chaining through H.
module sha256_stream_core #(
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter bit          ENABLE_224       = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] chunk,
  input  logic         first,
  input  logic         mode_224,
  output logic         busy,
  output logic         hash_valid,
  output logic [255:0] hash
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 ||
        ROUNDS_PER_CYCLE == 4 || ROUNDS_PER_CYCLE == 8)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_e;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e        state_q, state_d;
  logic [31:0]   w_q [16], w_d [16];
  logic [31:0]   work_q [8], work_d [8];
  logic [31:0]   h_q [8], h_d [8];
  logic [5:0]    t_q, t_d;
  logic          mode_q, mode_d;
  logic [255:0]  hash_q, hash_d;
  logic          hash_valid_q, hash_valid_d;

  logic [31:0]   ww [16];
  logic [31:0]   wk [8];
  logic [31:0]   t1, t2, nw;
  logic [5:0]    kidx;
  logic [6:0]    tsum;
  logic          sel224;

  assign sel224     = mode_224 & ENABLE_224;
  assign in_ready   = (state_q == S_IDLE) && !reset;
  assign busy       = (state_q != S_IDLE);
  assign hash_valid = hash_valid_q;
  assign hash       = hash_q;

  always_comb begin
    state_d      = state_q;
    t_d          = t_q;
    mode_d       = mode_q;
    hash_d       = hash_q;
    hash_valid_d = 1'b0;
    w_d          = w_q;
    work_d       = work_q;
    h_d          = h_q;
    ww           = w_q;
    wk           = work_q;
    t1           = '0;
    t2           = '0;
    nw           = '0;
    kidx         = '0;
    tsum         = '0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < 16; i++) w_d[i] = chunk[511 - 32*i -: 32];
          if (first) begin
            for (int unsigned i = 0; i < 8; i++) h_d[i] = sel224 ? IV224[i] : IV256[i];
            mode_d = sel224;
          end
          work_d  = h_d;
          t_d     = '0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        // Rounds chain combinationally; the window always holds W[t..t+15] so w[0] is W[t].
        for (int unsigned r = 0; r < ROUNDS_PER_CYCLE; r++) begin
          kidx = t_q + 6'(r);
          t1 = wk[7] + (rotr(wk[4], 6) ^ rotr(wk[4], 11) ^ rotr(wk[4], 25))
             + ((wk[4] & wk[5]) ^ (~wk[4] & wk[6])) + K[kidx] + ww[0];
          t2 = (rotr(wk[0], 2) ^ rotr(wk[0], 13) ^ rotr(wk[0], 22))
             + ((wk[0] & wk[1]) ^ (wk[0] & wk[2]) ^ (wk[1] & wk[2]));
          nw = (rotr(ww[14], 17) ^ rotr(ww[14], 19) ^ (ww[14] >> 10)) + ww[9]
             + (rotr(ww[1], 7) ^ rotr(ww[1], 18) ^ (ww[1] >> 3)) + ww[0];
          for (int unsigned j = 7; j > 0; j--) wk[j] = wk[j-1];
          wk[4] = wk[4] + t1;
          wk[0] = t1 + t2;
          for (int unsigned j = 0; j < 15; j++) ww[j] = ww[j+1];
          ww[15] = nw;
        end
        work_d = wk;
        w_d    = ww;
        tsum   = {1'b0, t_q} + 7'(ROUNDS_PER_CYCLE);
        t_d    = tsum[5:0];
        if (tsum[6]) state_d = S_FINAL;
      end
      S_FINAL: begin
        for (int unsigned i = 0; i < 8; i++) h_d[i] = h_q[i] + work_q[i];
        hash_d = {h_d[0], h_d[1], h_d[2], h_d[3], h_d[4], h_d[5], h_d[6],
                  mode_q ? 32'h0 : h_d[7]};
        hash_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      t_q          <= '0;
      mode_q       <= 1'b0;
      hash_q       <= '0;
      hash_valid_q <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        work_q[i] <= '0;
        h_q[i]    <= '0;
      end
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      mode_q       <= mode_d;
      hash_q       <= hash_d;
      hash_valid_q <= hash_valid_d;
      w_q          <= w_d;
      work_q       <= work_d;
      h_q          <= h_d;
    end
  end

endmodule
